// File: rtl/regfile_rdport_if.sv
// Register-file access bus: one write port plus NRD registered read ports.
interface regfile_rdport_if #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned AW    = 5,
    parameter int unsigned NRD   = 2
) ();
    logic                 wr_en;
    logic [AW-1:0]        wr_addr;
    logic [WIDTH-1:0]     wr_data;
    logic [NRD-1:0]       rd_en;
    logic [NRD*AW-1:0]    rd_addr;
    logic                 stall;
    logic [NRD*WIDTH-1:0] rd_data;
    logic [NRD-1:0]       rd_valid;

    // Decode/execute side: issues writes and read requests, receives operands.
    modport master (
        output wr_en, wr_addr, wr_data, rd_en, rd_addr, stall,
        input  rd_data, rd_valid
    );

    // Register file side.
    modport slave (
        input  wr_en, wr_addr, wr_data, rd_en, rd_addr, stall,
        output rd_data, rd_valid
    );
endinterface

// File: rtl/regfile_rdport.sv
// Parametrised register file: DEPTH x WIDTH storage, one write port and
// NRD one-cycle-latency read ports with stall hold, write bypass and an
// optional hardwired-zero register 0.
module regfile_rdport #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned AW       = 5,
    parameter int unsigned NRD      = 2,
    parameter int unsigned ZERO_REG = 1
) (
    input logic             clk_i,
    input logic             reset_i,
    regfile_rdport_if.slave rf_bus
);
    localparam int unsigned DEPTH = 2 ** AW;

    logic [WIDTH-1:0]     mem_q [DEPTH];
    logic [NRD*WIDTH-1:0] rd_data_q;
    logic [NRD*WIDTH-1:0] rd_data_d;
    logic [NRD-1:0]       rd_valid_q;
    logic [NRD-1:0]       rd_valid_d;
    logic [WIDTH-1:0]     sel      [NRD];
    logic                 wr_ok;

    assign wr_ok = rf_bus.wr_en && !((ZERO_REG != 0) && (rf_bus.wr_addr == '0));

    // Storage: cleared by reset, written independently of stall.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_ok) begin
            mem_q[rf_bus.wr_addr] <= rf_bus.wr_data;
        end
    end

    // Per-port read value: zero register, then same-edge write bypass, then storage.
    always_comb begin
        for (int unsigned p = 0; p < NRD; p++) begin
            sel[p] = mem_q[rf_bus.rd_addr[p*AW +: AW]];
            if ((ZERO_REG != 0) && (rf_bus.rd_addr[p*AW +: AW] == '0)) begin
                sel[p] = '0;
            end else if (rf_bus.wr_en && (rf_bus.wr_addr == rf_bus.rd_addr[p*AW +: AW])) begin
                sel[p] = rf_bus.wr_data;
            end
        end
    end

    // Next read outputs: hold everything on stall, otherwise accept per-port requests.
    always_comb begin
        rd_data_d  = rd_data_q;
        rd_valid_d = rd_valid_q;
        if (!rf_bus.stall) begin
            for (int unsigned p = 0; p < NRD; p++) begin
                rd_valid_d[p] = rf_bus.rd_en[p];
                if (rf_bus.rd_en[p]) begin
                    rd_data_d[p*WIDTH +: WIDTH] = sel[p];
                end
            end
        end
    end

    // Read output registers.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            rd_data_q  <= '0;
            rd_valid_q <= '0;
        end else begin
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    assign rf_bus.rd_data  = rd_data_q;
    assign rf_bus.rd_valid = rd_valid_q;
endmodule

// File: tb/tb_regfile_rdport.sv
// Directed bench for regfile_rdport: one instance with the zero register,
// one without, both driven with identical stimulus.
module tb_regfile_rdport;
    logic clk;
    logic reset;
    int   n_cmp;
    int   n_fail;

    regfile_rdport_if #(.WIDTH(32), .AW(5), .NRD(2)) bus_z ();
    regfile_rdport_if #(.WIDTH(32), .AW(5), .NRD(2)) bus_n ();

    regfile_rdport #(.WIDTH(32), .AW(5), .NRD(2), .ZERO_REG(1)) dut (
        .clk_i(clk), .reset_i(reset), .rf_bus(bus_z.slave)
    );
    regfile_rdport #(.WIDTH(32), .AW(5), .NRD(2), .ZERO_REG(0)) dut_nz (
        .clk_i(clk), .reset_i(reset), .rf_bus(bus_n.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                         input logic [1:0] re, input logic [4:0] ra0, input logic [4:0] ra1,
                         input logic st);
        bus_z.wr_en = we; bus_z.wr_addr = wa; bus_z.wr_data = wd;
        bus_z.rd_en = re; bus_z.rd_addr = {ra1, ra0}; bus_z.stall = st;
        bus_n.wr_en = we; bus_n.wr_addr = wa; bus_n.wr_data = wd;
        bus_n.rd_en = re; bus_n.rd_addr = {ra1, ra0}; bus_n.stall = st;
    endtask

    // Advance one rising edge and settle 1 time unit past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(1'b1, 5'd3, 32'hFFFF_0000, 2'b11, 5'd3, 5'd17, 1'b0);
        tick();
        tick();
        n_cmp++;
        if (bus_z.rd_valid !== 2'b00) begin
            n_fail++; $display("FAIL reset_valid got=%b exp=%b", bus_z.rd_valid, 2'b00);
        end
        n_cmp++;
        if (bus_z.rd_data !== 64'h0) begin
            n_fail++; $display("FAIL reset_data got=%h exp=%h", bus_z.rd_data, 64'h0);
        end
        reset = 1'b0;
        drive(1'b0, 5'd0, 32'h0, 2'b11, 5'd3, 5'd17, 1'b0);
        tick();
        n_cmp++;
        if (bus_z.rd_valid !== 2'b11) begin
            n_fail++; $display("FAIL post_reset_valid got=%b exp=%b", bus_z.rd_valid, 2'b11);
        end
        n_cmp++;
        if (bus_z.rd_data !== 64'h0) begin
            n_fail++; $display("FAIL post_reset_data got=%h exp=%h", bus_z.rd_data, 64'h0);
        end
    endtask

    task automatic test_write_read();
        drive(1'b1, 5'd5, 32'hDEAD_BEEF, 2'b00, 5'd0, 5'd0, 1'b0);
        tick();
        n_cmp++;
        if (bus_z.rd_valid !== 2'b00) begin
            n_fail++; $display("FAIL idle_valid got=%b exp=%b", bus_z.rd_valid, 2'b00);
        end
        drive(1'b0, 5'd0, 32'h0, 2'b01, 5'd5, 5'd0, 1'b0);
        tick();
        n_cmp++;
        if (bus_z.rd_data[31:0] !== 32'hDEAD_BEEF) begin
            n_fail++; $display("FAIL wr_rd_data0 got=%h exp=%h", bus_z.rd_data[31:0], 32'hDEAD_BEEF);
        end
        n_cmp++;
        if (bus_z.rd_valid !== 2'b01) begin
            n_fail++; $display("FAIL wr_rd_valid got=%b exp=%b", bus_z.rd_valid, 2'b01);
        end
        n_cmp++;
        if (bus_z.rd_data[63:32] !== 32'h0) begin
            n_fail++; $display("FAIL wr_rd_hold1 got=%h exp=%h", bus_z.rd_data[63:32], 32'h0);
        end
    endtask

    task automatic test_bypass();
        drive(1'b1, 5'd9, 32'h0000_0001, 2'b00, 5'd0, 5'd0, 1'b0);
        tick();
        drive(1'b1, 5'd9, 32'h1234_5678, 2'b10, 5'd0, 5'd9, 1'b0);
        tick();
        n_cmp++;
        if (bus_z.rd_data[63:32] !== 32'h1234_5678) begin
            n_fail++; $display("FAIL bypass_data1 got=%h exp=%h", bus_z.rd_data[63:32], 32'h1234_5678);
        end
        n_cmp++;
        if (bus_z.rd_valid !== 2'b10) begin
            n_fail++; $display("FAIL bypass_valid got=%b exp=%b", bus_z.rd_valid, 2'b10);
        end
        drive(1'b0, 5'd0, 32'h0, 2'b10, 5'd0, 5'd9, 1'b0);
        tick();
        n_cmp++;
        if (bus_z.rd_data[63:32] !== 32'h1234_5678) begin
            n_fail++; $display("FAIL after_bypass_data1 got=%h exp=%h", bus_z.rd_data[63:32], 32'h1234_5678);
        end
    endtask

    task automatic test_zero_reg();
        drive(1'b1, 5'd0, 32'hFFFF_FFFF, 2'b00, 5'd0, 5'd0, 1'b0);
        tick();
        drive(1'b0, 5'd0, 32'h0, 2'b11, 5'd0, 5'd0, 1'b0);
        tick();
        n_cmp++;
        if (bus_z.rd_data !== 64'h0) begin
            n_fail++; $display("FAIL zero_reg_data got=%h exp=%h", bus_z.rd_data, 64'h0);
        end
        n_cmp++;
        if (bus_n.rd_data !== 64'hFFFF_FFFF_FFFF_FFFF) begin
            n_fail++; $display("FAIL nonzero_reg_data got=%h exp=%h", bus_n.rd_data, 64'hFFFF_FFFF_FFFF_FFFF);
        end
        // Same-edge write to register 0 must not bypass through the zero register.
        drive(1'b1, 5'd0, 32'hCAFE_F00D, 2'b01, 5'd0, 5'd0, 1'b0);
        tick();
        n_cmp++;
        if (bus_z.rd_data[31:0] !== 32'h0) begin
            n_fail++; $display("FAIL zero_reg_bypass got=%h exp=%h", bus_z.rd_data[31:0], 32'h0);
        end
        n_cmp++;
        if (bus_n.rd_data[31:0] !== 32'hCAFE_F00D) begin
            n_fail++; $display("FAIL nonzero_reg_bypass got=%h exp=%h", bus_n.rd_data[31:0], 32'hCAFE_F00D);
        end
    endtask

    task automatic test_stall();
        drive(1'b0, 5'd0, 32'h0, 2'b01, 5'd5, 5'd0, 1'b0);
        tick();
        n_cmp++;
        if (bus_z.rd_data[31:0] !== 32'hDEAD_BEEF) begin
            n_fail++; $display("FAIL pre_stall_data0 got=%h exp=%h", bus_z.rd_data[31:0], 32'hDEAD_BEEF);
        end
        drive(1'b1, 5'd5, 32'hA5A5_A5A5, 2'b11, 5'd9, 5'd9, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++;
            if (bus_z.rd_data[31:0] !== 32'hDEAD_BEEF) begin
                n_fail++; $display("FAIL stall_data0[%0d] got=%h exp=%h", i, bus_z.rd_data[31:0], 32'hDEAD_BEEF);
            end
            n_cmp++;
            if (bus_z.rd_valid !== 2'b01) begin
                n_fail++; $display("FAIL stall_valid[%0d] got=%b exp=%b", i, bus_z.rd_valid, 2'b01);
            end
        end
        drive(1'b0, 5'd0, 32'h0, 2'b01, 5'd5, 5'd0, 1'b0);
        tick();
        n_cmp++;
        if (bus_z.rd_data[31:0] !== 32'hA5A5_A5A5) begin
            n_fail++; $display("FAIL post_stall_data0 got=%h exp=%h", bus_z.rd_data[31:0], 32'hA5A5_A5A5);
        end
        n_cmp++;
        if (bus_z.rd_valid !== 2'b01) begin
            n_fail++; $display("FAIL post_stall_valid got=%b exp=%b", bus_z.rd_valid, 2'b01);
        end
    endtask

    task automatic test_back_to_back();
        drive(1'b0, 5'd0, 32'h0, 2'b11, 5'd9, 5'd5, 1'b0);
        tick();
        n_cmp++;
        if (bus_z.rd_data !== {32'hA5A5_A5A5, 32'h1234_5678}) begin
            n_fail++; $display("FAIL b2b_data_a got=%h exp=%h", bus_z.rd_data, {32'hA5A5_A5A5, 32'h1234_5678});
        end
        drive(1'b0, 5'd0, 32'h0, 2'b11, 5'd5, 5'd5, 1'b0);
        tick();
        n_cmp++;
        if (bus_z.rd_data !== {32'hA5A5_A5A5, 32'hA5A5_A5A5}) begin
            n_fail++; $display("FAIL b2b_same_addr got=%h exp=%h", bus_z.rd_data, {32'hA5A5_A5A5, 32'hA5A5_A5A5});
        end
        n_cmp++;
        if (bus_z.rd_valid !== 2'b11) begin
            n_fail++; $display("FAIL b2b_valid got=%b exp=%b", bus_z.rd_valid, 2'b11);
        end
        drive(1'b0, 5'd0, 32'h0, 2'b00, 5'd9, 5'd9, 1'b0);
        tick();
        n_cmp++;
        if (bus_z.rd_valid !== 2'b00) begin
            n_fail++; $display("FAIL b2b_drop_valid got=%b exp=%b", bus_z.rd_valid, 2'b00);
        end
        n_cmp++;
        if (bus_z.rd_data !== {32'hA5A5_A5A5, 32'hA5A5_A5A5}) begin
            n_fail++; $display("FAIL b2b_hold_data got=%h exp=%h", bus_z.rd_data, {32'hA5A5_A5A5, 32'hA5A5_A5A5});
        end
    endtask

    task automatic test_reset_mid();
        drive(1'b0, 5'd0, 32'h0, 2'b01, 5'd5, 5'd0, 1'b0);
        tick();
        n_cmp++;
        if (bus_z.rd_data[31:0] !== 32'hA5A5_A5A5) begin
            n_fail++; $display("FAIL pre_reset_data0 got=%h exp=%h", bus_z.rd_data[31:0], 32'hA5A5_A5A5);
        end
        reset = 1'b1;
        drive(1'b1, 5'd5, 32'h5555_AAAA, 2'b01, 5'd5, 5'd0, 1'b1);
        tick();
        n_cmp++;
        if (bus_z.rd_valid !== 2'b00) begin
            n_fail++; $display("FAIL mid_reset_valid got=%b exp=%b", bus_z.rd_valid, 2'b00);
        end
        n_cmp++;
        if (bus_z.rd_data !== 64'h0) begin
            n_fail++; $display("FAIL mid_reset_data got=%h exp=%h", bus_z.rd_data, 64'h0);
        end
        reset = 1'b0;
        drive(1'b0, 5'd0, 32'h0, 2'b01, 5'd5, 5'd0, 1'b0);
        tick();
        n_cmp++;
        if (bus_z.rd_data[31:0] !== 32'h0) begin
            n_fail++; $display("FAIL after_reset_mem got=%h exp=%h", bus_z.rd_data[31:0], 32'h0);
        end
        n_cmp++;
        if (bus_z.rd_valid !== 2'b01) begin
            n_fail++; $display("FAIL after_reset_valid got=%b exp=%b", bus_z.rd_valid, 2'b01);
        end
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        reset  = 1'b1;
        drive(1'b0, 5'd0, 32'h0, 2'b00, 5'd0, 5'd0, 1'b0);
        test_reset();
        test_write_read();
        test_bypass();
        test_zero_reg();
        test_stall();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/regfile_rdport.md
# regfile_rdport

Parametrised register-file storage with registered multi-port reads, for the CPU datapath. It replaces the fixed 32-input, 32-bit read multiplexer with a configurable array of DEPTH registers, WIDTH bits each, exposing NRD independent read ports and one write port. Each read has one-cycle latency with a valid flag, a stall hold, same-cycle write-to-read bypass, and an optional hardwired-zero register 0. It sits between instruction decode (addresses) and the execute-stage operand latches.

## Interface
- WIDTH, 32, data width of each register
- AW, 5, address width; DEPTH = 2**AW registers
- NRD, 2, number of read ports (1..4)
- ZERO_REG, 1, when 1, register 0 reads as 0 and ignores writes
- clk  input  1  single clock; all state changes on rising edge
- reset  input  1  synchronous, active-high; clears all state on the rising edge where it is high
- wr_en  input  1  write strobe
- wr_addr  input  AW  write address
- wr_data  input  WIDTH  write data
- rd_en  input  NRD  per-port read request; bit p belongs to port p
- rd_addr  input  NRD*AW  port p address at bits [p*AW +: AW]
- stall  input  1  holds all read outputs; pending requests are not accepted
- rd_data  output  NRD*WIDTH  port p data at bits [p*WIDTH +: WIDTH], registered
- rd_valid  output  NRD  port p data valid, registered

## Operation
- Storage: DEPTH x WIDTH registers, all cleared to 0 by reset.
- Write: on an edge with wr_en=1 and reset=0, mem[wr_addr] <= wr_data.
  - Ignored when ZERO_REG=1 and wr_addr=0.
  - Writes are performed regardless of stall.
- Read acceptance: on an edge with reset=0 and stall=0, each port p independently:
  - rd_valid[p] <= rd_en[p].
  - If rd_en[p]=1, rd_data[p] <= selected value.
  - If rd_en[p]=0, rd_data[p] holds its previous value.
- Selected value, in priority order:
  - 0 if ZERO_REG=1 and addr=0.
  - Otherwise wr_data if wr_en=1 and wr_addr=addr (bypass: new data is returned, not the pre-write contents).
  - Otherwise mem[addr].
- Stall: while stall=1, rd_data and rd_valid hold their values exactly. rd_en/rd_addr in stall cycles are discarded; the requester re-presents them after stall deasserts.
- Multiple ports may read the same address in the same cycle; all receive identical data.
- A read port never alters storage.
- Arithmetic: none. Addresses are full-range, so no out-of-range case exists (DEPTH = 2**AW).

## Timing
- Reset: the edge with reset=1 sets every mem entry, every rd_data and every rd_valid to 0.
  - reset overrides wr_en, rd_en and stall on that edge.
  - Reset mid-stall or mid-read drops the in-flight valid. Outputs are 0 from the cycle after that edge.
- Read latency: exactly 1 cycle. Request at edge N (stall=0) gives data and valid visible after edge N, i.e. during cycle N+1.
- Throughput: one read per port per cycle when stall=0. Back-to-back requests produce continuous valid.
- Write-to-read:
  - Same-edge write and read of the same address returns the new data (bypass).
  - A read on the edge after the write returns the stored data.
  - There is no cycle in which stale data is returned.
- Stall asserted at edge N: outputs from edge N-1 are held through every stalled edge. The first edge with stall=0 accepts new requests.
- All outputs change only on rising clk edges; there are no combinational paths from inputs to outputs.

## Test plan
- Reset then read: assert reset 2 cycles, then rd_en=2'b11 with addr 3 and 17 -> next cycle rd_valid=2'b11, rd_data both 0.
- Write then read: write 0xDEADBEEF to addr 5; next cycle read port0 addr 5 -> 0xDEADBEEF one cycle later, rd_valid[0]=1, rd_valid[1]=0.
- Bypass: same edge wr_en=1 wr_addr=9 wr_data=0x12345678 and port1 reads addr 9 (mem[9] previously 0x1) -> rd_data[1]=0x12345678.
- Zero register: write 0xFFFFFFFF to addr 0, then read addr 0 on both ports -> 0. Repeat with ZERO_REG=0 -> 0xFFFFFFFF.
- Stall hold: read addr 5 (0xDEADBEEF), assert stall 3 cycles while presenting addr 9 and writing addr 5=0xA5A5A5A5 -> outputs stay 0xDEADBEEF/valid=1 for 3 cycles. After release, reading addr 5 returns 0xA5A5A5A5.
- Reset mid-operation: continuous reads of addr 5 with reset pulsed for 1 cycle -> valid=0 and data=0 the cycle after. The next read of addr 5 returns 0.
